// File: rtl/uart_recv_if.sv
// Serial receive bundle for uart_recv: the raw rx line plus the received-byte
// outputs. Compile-time option: UART_RECV_MAJORITY_EN (see uart_recv.sv).
interface uart_recv_if;
  logic       UART_rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;

  modport master (
    output UART_rx,
    input  rx_data,
    input  rx_done,
    input  frame_err
  );

  modport slave (
    input  UART_rx,
    output rx_data,
    output rx_done,
    output frame_err
  );
endinterface

// File: rtl/uart_recv.sv
// 8N1 UART receiver with mid-bit sampling and stop-bit framing check.
// Define UART_RECV_MAJORITY_EN for 2-of-3 majority voting around each sample point.
module uart_recv #(
  parameter logic [25:0] CLK  = 26'd50000000,
  parameter logic [16:0] BAUD = 17'd115200
) (
  input  logic       clk,
  input  logic       rstn,
  uart_recv_if.slave u_if
);

  localparam int BAUD_CLK = int'(CLK / 26'(BAUD));
  localparam int HALF_CLK = BAUD_CLK / 2;
  localparam int CNT_W    = (BAUD_CLK > 2) ? $clog2(BAUD_CLK) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_CLK - 1);
`ifdef UART_RECV_MAJORITY_EN
  localparam logic [CNT_W-1:0] SAMP0_PT  = CNT_W'(HALF_CLK - 2);
  localparam logic [CNT_W-1:0] SAMP1_PT  = CNT_W'(HALF_CLK - 1);
  localparam logic [CNT_W-1:0] DECIDE_PT = CNT_W'(HALF_CLK);
`else
  localparam logic [CNT_W-1:0] DECIDE_PT = CNT_W'(HALF_CLK - 1);
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  state_t           r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_done;
  logic             r_frame_err;

  logic w_fall;
  logic w_tick;
  logic w_bit;

  // Synchronizers reset high so a released reset never looks like a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= u_if.UART_rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_fall = r_sync3 & ~r_sync2;
  assign w_tick = (r_baud_cnt == DECIDE_PT);

`ifdef UART_RECV_MAJORITY_EN
  logic r_samp0;
  logic r_samp1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_samp0 <= 1'b1;
      r_samp1 <= 1'b1;
    end else begin
      if (r_baud_cnt == SAMP0_PT) r_samp0 <= r_sync2;
      if (r_baud_cnt == SAMP1_PT) r_samp1 <= r_sync2;
    end
  end

  assign w_bit = (r_samp0 & r_samp1) | (r_samp0 & r_sync2) | (r_samp1 & r_sync2);
`else
  assign w_bit = r_sync2;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_baud_cnt <= '0;
          if (w_fall) r_state <= START;
        end
        START: begin
          r_baud_cnt <= (r_baud_cnt == CNT_MAX) ? '0 : r_baud_cnt + 1'b1;
          if (w_tick) begin
            if (w_bit) begin
              r_state <= IDLE;
            end else begin
              r_state   <= DATA;
              r_bit_cnt <= 3'd0;
            end
          end
        end
        DATA: begin
          r_baud_cnt <= (r_baud_cnt == CNT_MAX) ? '0 : r_baud_cnt + 1'b1;
          if (w_tick) begin
            r_shift[r_bit_cnt] <= w_bit;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= STOP;
          end
        end
        STOP: begin
          r_baud_cnt <= (r_baud_cnt == CNT_MAX) ? '0 : r_baud_cnt + 1'b1;
          if (w_tick) begin
            if (w_bit) begin
              r_rx_data <= r_shift;
              r_rx_done <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          // A held-low break must not look like a new start bit.
          r_baud_cnt <= '0;
          if (r_sync2) r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_baud_cnt <= '0;
        end
      endcase
    end
  end

  assign u_if.rx_data   = r_rx_data;
  assign u_if.rx_done   = r_rx_done;
  assign u_if.frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: scenario tasks with random frames
// compared against a byte-queue reference model.
`timescale 1ns/1ps
module tb_uart_recv;

  localparam logic [25:0] P_CLK  = 26'd50000000;
  localparam logic [16:0] P_BAUD = 17'd115200;
  localparam int BAUD_CLK = 434;
  localparam int HALF_CLK = 217;
  localparam int LAT_NOM  = 9 * BAUD_CLK + HALF_CLK + 3;
`ifdef UART_RECV_MAJORITY_EN
  localparam int LAT_MAX  = LAT_NOM + 2;
`else
  localparam int LAT_MAX  = LAT_NOM + 1;
`endif
  localparam int LAT_MIN  = LAT_NOM - 1;
  localparam int NO_ABORT = 1 << 30;

  logic clk;
  logic rstn;
  uart_recv_if u_if ();

  uart_recv #(.CLK(P_CLK), .BAUD(P_BAUD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .u_if (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: the scenario tasks compare these against their own expectations.
  int         done_cyc_q[$];
  logic [7:0] done_data_q[$];
  int         start_q[$];
  int         fe_cnt   = 0;
  int         both_cnt = 0;
  int         wide_cnt = 0;
  logic       prev_done = 1'b0;

  always @(negedge clk) begin
    prev_done <= u_if.rx_done;
    if (u_if.rx_done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_data_q.push_back(u_if.rx_data);
      $display("rx_done: byte %h at cycle %0d", u_if.rx_data, cyc);
      if (prev_done === 1'b1) wide_cnt <= wide_cnt + 1;
    end
    if (u_if.frame_err === 1'b1) begin
      fe_cnt <= fe_cnt + 1;
      $display("frame_err pulse at cycle %0d", cyc);
    end
    if (u_if.rx_done === 1'b1 && u_if.frame_err === 1'b1) both_cnt <= both_cnt + 1;
  end

  int checks = 0;
  int passed = 0;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; optional 1-clk inversion
  // at the centre of each data bit; stops early after max_cyc cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic glitch, input int max_cyc);
    logic [9:0] bits;
    int n;
    bits = {stop_b, d, 1'b0};
    n = 0;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < BAUD_CLK; c++) begin
        if (n == max_cyc) return;
        @(negedge clk);
        if (k == 0 && c == 0) start_q.push_back(cyc);
        u_if.UART_rx = (glitch && k >= 1 && k <= 8 && c == HALF_CLK) ? ~bits[k] : bits[k];
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    u_if.UART_rx = 1'b1;
    idle(3);
    checks++; if (u_if.rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", u_if.rx_data); else passed++;
    checks++; if (u_if.rx_done !== 1'b0) $display("FAIL reset_rx_done: got %b want 0", u_if.rx_done); else passed++;
    checks++; if (u_if.frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", u_if.frame_err); else passed++;
    rstn = 1'b1;
    idle(50);
    checks++; if (done_data_q.size() != 0 || fe_cnt != 0) $display("FAIL reset_quiet: got %0d done %0d err want 0 0", done_data_q.size(), fe_cnt); else passed++;
  endtask

  task automatic test_single();
    int base, sbase, fe0, lat;
    base = done_data_q.size(); sbase = start_q.size(); fe0 = fe_cnt;
    send_frame(8'h55, 1'b1, 1'b0, NO_ABORT);
    idle(BAUD_CLK);
    checks++; if (done_data_q.size() != base + 1) $display("FAIL single_count: got %0d want %0d", done_data_q.size(), base + 1); else passed++;
    if (done_data_q.size() > base) begin
      checks++; if (done_data_q[base] !== 8'h55) $display("FAIL single_data: got %h want 55", done_data_q[base]); else passed++;
      lat = done_cyc_q[base] - start_q[sbase];
      checks++; if (lat < LAT_MIN || lat > LAT_MAX) $display("FAIL single_latency: got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); else passed++;
    end
    checks++; if (fe_cnt != fe0) $display("FAIL single_frame_err: got %0d want %0d", fe_cnt, fe0); else passed++;
    checks++; if (u_if.rx_data !== 8'h55) $display("FAIL single_hold: got %h want 55", u_if.rx_data); else passed++;
  endtask

  task automatic test_back_to_back();
    int base, gap;
    base = done_data_q.size();
    send_frame(8'hA3, 1'b1, 1'b0, NO_ABORT);
    send_frame(8'h0F, 1'b1, 1'b0, NO_ABORT);
    idle(BAUD_CLK);
    checks++; if (done_data_q.size() != base + 2) $display("FAIL b2b_count: got %0d want %0d", done_data_q.size(), base + 2); else passed++;
    if (done_data_q.size() >= base + 2) begin
      checks++; if (done_data_q[base] !== 8'hA3) $display("FAIL b2b_first: got %h want a3", done_data_q[base]); else passed++;
      checks++; if (done_data_q[base+1] !== 8'h0F) $display("FAIL b2b_second: got %h want 0f", done_data_q[base+1]); else passed++;
      gap = done_cyc_q[base+1] - done_cyc_q[base];
      checks++; if (gap < 10 * BAUD_CLK - 2 || gap > 10 * BAUD_CLK + 2) $display("FAIL b2b_gap: got %0d want about %0d", gap, 10 * BAUD_CLK); else passed++;
    end
  endtask

  task automatic test_start_glitch();
    int base, fe0;
    base = done_data_q.size(); fe0 = fe_cnt;
    @(negedge clk); u_if.UART_rx = 1'b0;
    idle(100);
    u_if.UART_rx = 1'b1;
    idle(2 * BAUD_CLK);
    checks++; if (done_data_q.size() != base || fe_cnt != fe0) $display("FAIL glitch_no_pulse: got %0d done %0d err want %0d %0d", done_data_q.size(), fe_cnt, base, fe0); else passed++;
    send_frame(8'h3C, 1'b1, 1'b0, NO_ABORT);
    idle(BAUD_CLK);
    checks++; if (done_data_q.size() != base + 1) $display("FAIL glitch_follow_count: got %0d want %0d", done_data_q.size(), base + 1); else passed++;
    checks++; if (u_if.rx_data !== 8'h3C) $display("FAIL glitch_follow_data: got %h want 3c", u_if.rx_data); else passed++;
  endtask

  task automatic test_frame_err();
    int base, fe0;
    base = done_data_q.size(); fe0 = fe_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, NO_ABORT);
    idle(2000);
    checks++; if (fe_cnt != fe0 + 1) $display("FAIL ferr_count: got %0d want %0d", fe_cnt, fe0 + 1); else passed++;
    checks++; if (done_data_q.size() != base) $display("FAIL ferr_no_done: got %0d want %0d", done_data_q.size(), base); else passed++;
    checks++; if (u_if.rx_data !== 8'h3C) $display("FAIL ferr_hold: got %h want 3c", u_if.rx_data); else passed++;
    u_if.UART_rx = 1'b1;
    idle(BAUD_CLK);
    send_frame(8'h12, 1'b1, 1'b0, NO_ABORT);
    idle(BAUD_CLK);
    checks++; if (done_data_q.size() != base + 1) $display("FAIL ferr_next_count: got %0d want %0d", done_data_q.size(), base + 1); else passed++;
    checks++; if (u_if.rx_data !== 8'h12) $display("FAIL ferr_next_data: got %h want 12", u_if.rx_data); else passed++;
    checks++; if (fe_cnt != fe0 + 1) $display("FAIL ferr_no_retrigger: got %0d want %0d", fe_cnt, fe0 + 1); else passed++;
  endtask

  task automatic test_reset_midframe();
    int base, fe0;
    base = done_data_q.size(); fe0 = fe_cnt;
    send_frame(8'h99, 1'b1, 1'b0, 5 * BAUD_CLK + 100);
    @(negedge clk);
    rstn = 1'b0;
    u_if.UART_rx = 1'b1;
    @(negedge clk);
    checks++; if (u_if.rx_data !== 8'h00) $display("FAIL rstmid_rx_data: got %h want 00", u_if.rx_data); else passed++;
    idle(10);
    rstn = 1'b1;
    idle(2 * BAUD_CLK);
    checks++; if (done_data_q.size() != base || fe_cnt != fe0) $display("FAIL rstmid_no_pulse: got %0d done %0d err want %0d %0d", done_data_q.size(), fe_cnt, base, fe0); else passed++;
    send_frame(8'h66, 1'b1, 1'b0, NO_ABORT);
    idle(BAUD_CLK);
    checks++; if (done_data_q.size() != base + 1) $display("FAIL rstmid_next_count: got %0d want %0d", done_data_q.size(), base + 1); else passed++;
    checks++; if (u_if.rx_data !== 8'h66) $display("FAIL rstmid_next_data: got %h want 66", u_if.rx_data); else passed++;
  endtask

  task automatic test_sample_glitch();
    int base;
    logic [7:0] exp;
`ifdef UART_RECV_MAJORITY_EN
    exp = 8'h81;
`else
    exp = 8'h7E;
`endif
    base = done_data_q.size();
    send_frame(8'h81, 1'b1, 1'b1, NO_ABORT);
    idle(BAUD_CLK);
    checks++; if (done_data_q.size() != base + 1) $display("FAIL sglitch_count: got %0d want %0d", done_data_q.size(), base + 1); else passed++;
    checks++; if (u_if.rx_data !== exp) $display("FAIL sglitch_data: got %h want %h", u_if.rx_data, exp); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int base;
    base = done_data_q.size();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1'b0, NO_ABORT);
    end
    idle(BAUD_CLK);
    checks++; if (done_data_q.size() != base + exp_q.size()) $display("FAIL rand_count: got %0d want %0d", done_data_q.size() - base, exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < done_data_q.size()) begin
        checks++; if (done_data_q[base+i] !== exp_q[i]) $display("FAIL rand_data[%0d]: got %h want %h", i, done_data_q[base+i], exp_q[i]); else passed++;
      end
    end
  endtask

  task automatic test_pulse_rules();
    checks++; if (both_cnt != 0) $display("FAIL done_and_err_together: got %0d want 0", both_cnt); else passed++;
    checks++; if (wide_cnt != 0) $display("FAIL done_width: got %0d extra cycles want 0", wide_cnt); else passed++;
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_start_glitch();
    test_frame_err();
    test_reset_midframe();
    test_sample_glitch();
    test_random();
    test_pulse_rules();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
